// File: rtl/vs1053_pkg.sv
// rtl/vs1053_pkg.sv - shared opcodes, state encoding and widths for the VS1053 SCI sequencer
package vs1053_pkg;

    localparam logic [7:0] SCI_READ  = 8'h03;
    localparam logic [7:0] SCI_WRITE = 8'h02;

    localparam int TMR_W = 20;
    localparam int IDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DREQ,
        ST_CS_SETUP,
        ST_ISSUE,
        ST_WAIT_BYTE,
        ST_CS_HOLD,
        ST_RESP
    } sci_state_t;

    // Byte 0 (opcode) goes out first, byte 3 (data low) last.
    function automatic logic [7:0] frame_byte(input logic [31:0] frame, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = frame[31:24];
            2'd1:    b = frame[23:16];
            2'd2:    b = frame[15:8];
            default: b = frame[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vs1053_cycle_timer.sv
// rtl/vs1053_cycle_timer.sv - loadable down-counter with a done flag at zero
module vs1053_cycle_timer
    import vs1053_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/vs1053_sci_ctrl.sv
// rtl/vs1053_sci_ctrl.sv - VS1053 SCI read/write sequencer over a byte SPI master
// Optional DREQ/byte timeout abort: define VS1053_SCI_TIMEOUT_EN.
module vs1053_sci_ctrl
    import vs1053_pkg::*;
#(
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    input  logic        dreq,
    output logic        xcs,
    output logic        spi_wr_en,
    output logic [7:0]  spi_tx,
    input  logic        spi_rx_done,
    input  logic [7:0]  spi_rx
);

    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CS_SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(CS_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD   = TMR_W'(TIMEOUT_CYC);

    sci_state_t        state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [31:0]       frame;
    logic              rw;
    logic [15:0]       rdata_cap;
    logic              accept;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_done;
    logic              timeout_hit;
    logic              cs_active_next;

    assign accept = (state == ST_IDLE) && cmd_valid;

    vs1053_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

`ifdef VS1053_SCI_TIMEOUT_EN
    assign timeout_hit = tmr_done &&
                         (((state == ST_WAIT_DREQ) && !dreq) ||
                          ((state == ST_WAIT_BYTE) && !spi_rx_done));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        tmr_load   = 1'b0;
        tmr_val    = SETUP_LOAD;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = ST_WAIT_DREQ;
                    idx_next   = '0;
                end
            end
            ST_WAIT_DREQ: begin
                if (dreq)             state_next = ST_CS_SETUP;
                else if (timeout_hit) state_next = ST_RESP;
            end
            ST_CS_SETUP: begin
                if (tmr_done) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_BYTE;
            end
            ST_WAIT_BYTE: begin
                if (spi_rx_done) begin
                    if (idx == 2'd3) begin
                        state_next = ST_CS_HOLD;
                    end else begin
                        idx_next   = idx + 2'd1;
                        state_next = ST_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_CS_HOLD: begin
                if (tmr_done) state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // One shared timer: every timed state reloads it on entry.
        if (state_next != state) begin
            case (state_next)
                ST_CS_SETUP: begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end
                ST_CS_HOLD: begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end
                ST_WAIT_DREQ, ST_WAIT_BYTE: begin
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
                end
                default: begin
                    tmr_load = 1'b0;
                end
            endcase
        end
    end

    assign cs_active_next = (state_next == ST_CS_SETUP) || (state_next == ST_ISSUE) ||
                            (state_next == ST_WAIT_BYTE) || (state_next == ST_CS_HOLD);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            frame     <= '0;
            rw        <= 1'b0;
            rdata_cap <= 16'h0000;
            xcs       <= 1'b1;
            spi_wr_en <= 1'b0;
            spi_tx    <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            idx <= idx_next;
            if (accept) begin
                rw        <= cmd_rw;
                frame     <= {(cmd_rw ? SCI_READ : SCI_WRITE), cmd_addr, cmd_wdata};
                rdata_cap <= 16'h0000;
            end
            if ((state == ST_WAIT_BYTE) && spi_rx_done && rw) begin
                if (idx == 2'd2) rdata_cap[15:8] <= spi_rx;
                if (idx == 2'd3) rdata_cap[7:0]  <= spi_rx;
            end
            xcs       <= !cs_active_next;
            spi_wr_en <= (state_next == ST_ISSUE);
            if (state_next == ST_ISSUE) begin
                spi_tx <= frame_byte(frame, idx_next);
            end
            rsp_valid <= (state_next == ST_RESP);
            if (state_next == ST_RESP) begin
                rsp_rdata <= (rw && !timeout_hit) ? rdata_cap : 16'h0000;
            end
            cmd_ready <= (state_next == ST_IDLE);
            busy      <= (state_next != ST_IDLE);
        end
    end

`ifdef VS1053_SCI_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= (state_next == ST_RESP) && timeout_hit;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_vs1053_sci_ctrl.sv
// tb/tb_vs1053_sci_ctrl.sv - randomized self-checking bench for vs1053_sci_ctrl
module tb_vs1053_sci_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        dreq = 1'b0;
    logic        xcs;
    logic        spi_wr_en;
    logic [7:0]  spi_tx;
    logic        spi_rx_done = 1'b0;
    logic [7:0]  spi_rx = 8'h00;

    int total = 0;
    int bad = 0;
    int gcyc = 0;
    int last_low = -1;

    vs1053_sci_ctrl #(
        .CS_SETUP_CYC (2),
        .CS_HOLD_CYC  (2),
        .TIMEOUT_CYC  (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .dreq        (dreq),
        .xcs         (xcs),
        .spi_wr_en   (spi_wr_en),
        .spi_tx      (spi_tx),
        .spi_rx_done (spi_rx_done),
        .spi_rx      (spi_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    // Reference: a transaction is the 4-byte frame {opcode, addr, wdata}; reads return {rx byte2, rx byte3}.
    task automatic run_cmd(input string nm, input bit rw, input logic [7:0] addr, input logic [15:0] wd,
                           input int dly, input bit stray, input bit hold_next, input int abort_byte,
                           input logic [7:0] rx_hi, input logic [7:0] rx_lo);
        logic [7:0]  exp_tx [4];
        logic [7:0]  got_tx [$];
        logic [15:0] exp_rd;
        logic [7:0]  cur_tx;
        int cyc, pulses, lat, setup_low, hold_low, first_low, wait_n;
        int viol_pre, viol_overlap, viol_xcs, viol_stable, ready_early;
        bit in_flight, done_seen, last_rx_sent, stray_done, aborted;

        exp_tx = '{(rw ? 8'h03 : 8'h02), addr, wd[15:8], wd[7:0]};
        exp_rd = rw ? {rx_hi, rx_lo} : 16'h0000;
        cyc = 0; pulses = 0; lat = 0; setup_low = 0; hold_low = 0; first_low = -1; wait_n = 0;
        viol_pre = 0; viol_overlap = 0; viol_xcs = 0; viol_stable = 0; ready_early = 0;
        in_flight = 0; done_seen = 0; last_rx_sent = 0; stray_done = 0; aborted = 0;
        cur_tx = 8'h00;

        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd;
        dreq = (dly == 0);
        while (!cmd_ready && wait_n < 200) begin
            tick;
            wait_n++;
        end
        chk({nm, "_accept_bound"}, 32'(wait_n < 200), 32'd1);
        tick;
        if (!hold_next) cmd_valid = 1'b0;
        chk({nm, "_busy_after_accept"}, {31'd0, busy}, 32'd1);

        while (!done_seen && !aborted && cyc < 400) begin
            if (cyc < dly && (!xcs || spi_wr_en)) viol_pre++;
            if (!xcs && first_low < 0) begin
                first_low = cyc;
                if (last_low >= 0) chk({nm, "_xcs_gap_ge2"}, 32'(gcyc - last_low - 1 >= 2), 32'd1);
            end
            if (!xcs) last_low = gcyc;
            if (!xcs && pulses == 0 && !spi_wr_en) setup_low++;
            if (!xcs && last_rx_sent) hold_low++;
            if (cmd_ready || !busy) ready_early++;
            if (in_flight && spi_tx !== cur_tx) viol_stable++;
            spi_rx_done = 1'b0;
            if (spi_wr_en) begin
                if (in_flight) viol_overlap++;
                if (xcs) viol_xcs++;
                got_tx.push_back(spi_tx);
                cur_tx = spi_tx;
                pulses++;
                in_flight = 1;
                lat = $urandom_range(1, 5);
                if (pulses == abort_byte) aborted = 1;
            end else if (in_flight) begin
                lat--;
                if (lat == 0) begin
                    spi_rx_done = 1'b1;
                    spi_rx = (pulses == 3) ? rx_hi : (pulses == 4) ? rx_lo : 8'($urandom);
                    in_flight = 0;
                    if (pulses == 4) last_rx_sent = 1;
                end
            end else if (stray && !stray_done && !xcs && pulses == 0) begin
                spi_rx_done = 1'b1;
                spi_rx = 8'hEE;
                stray_done = 1;
            end
            if (rsp_valid) done_seen = 1;
            if (!done_seen && !aborted) begin
                tick;
                cyc++;
                dreq = (cyc >= dly);
            end
        end

        if (aborted) begin
            rst = 1'b1;
            spi_rx_done = 1'b0;
            cmd_valid = 1'b0;
            tick;
            chk({nm, "_rst_xcs"}, {31'd0, xcs}, 32'd1);
            chk({nm, "_rst_wr_en"}, {31'd0, spi_wr_en}, 32'd0);
            chk({nm, "_rst_ready"}, {31'd0, cmd_ready}, 32'd1);
            rst = 1'b0;
            viol_pre = 0;
            for (int i = 0; i < 20; i++) begin
                if (rsp_valid || spi_wr_en || !xcs) viol_pre++;
                tick;
            end
            chk({nm, "_rst_no_rsp"}, 32'(viol_pre), 32'd0);
            return;
        end

        chk({nm, "_rsp_seen"}, {31'd0, done_seen}, 32'd1);
        if (!done_seen) return;
        chk({nm, "_pulses"}, 32'(pulses), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_tx%0d", nm, i), (i < got_tx.size()) ? {24'd0, got_tx[i]} : 32'hFFFF_FFFF,
                {24'd0, exp_tx[i]});
        chk({nm, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
        chk({nm, "_err"}, {31'd0, rsp_err}, 32'd0);
        chk({nm, "_setup_low"}, 32'(setup_low), 32'd2);
        chk({nm, "_hold_low"}, 32'(hold_low), 32'd2);
        chk({nm, "_violations"}, 32'(viol_pre + viol_overlap + viol_xcs + viol_stable), 32'd0);
        chk({nm, "_busy_until_rsp"}, 32'(ready_early), 32'd0);
        if (dly > 0) chk({nm, "_start_after_dreq"}, 32'(first_low - dly <= 2 && first_low > dly), 32'd1);
        tick;
        chk({nm, "_rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, "_ready_after_rsp"}, {31'd0, cmd_ready}, 32'd1);
        chk({nm, "_rdata_held"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
    endtask

    initial begin
        bit          r_rw;
        logic [7:0]  r_addr;
        logic [15:0] r_wd;

        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("reset_xcs", {31'd0, xcs}, 32'd1);
        chk("reset_wr_en", {31'd0, spi_wr_en}, 32'd0);
        chk("reset_tx", {24'd0, spi_tx}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("reset_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        run_cmd("wr0b", 1'b0, 8'h0B, 16'h2020, 0, 1'b0, 1'b0, 0, 8'h00, 8'h00);
        run_cmd("rd01", 1'b1, 8'h01, 16'h5555, 0, 1'b0, 1'b0, 0, 8'hAB, 8'hCD);
        run_cmd("dreq50", 1'b0, 8'h02, 16'h0800, 50, 1'b0, 1'b0, 0, 8'h00, 8'h00);
        run_cmd("stray_a", 1'b1, 8'h05, 16'h0000, 0, 1'b1, 1'b1, 0, 8'h12, 8'h34);
        run_cmd("stray_b", 1'b1, 8'h05, 16'h0000, 0, 1'b0, 1'b0, 0, 8'h56, 8'h78);
        run_cmd("abort", 1'b0, 8'h03, 16'h1234, 0, 1'b0, 1'b0, 3, 8'h00, 8'h00);
        run_cmd("post_abort", 1'b1, 8'h0C, 16'h0000, 0, 1'b0, 1'b0, 0, 8'h9A, 8'hBC);

        for (int n = 0; n < 10; n++) begin
            r_rw   = 1'($urandom);
            r_addr = 8'($urandom);
            r_wd   = 16'($urandom);
            run_cmd($sformatf("rnd%0d", n), r_rw, r_addr, r_wd, $urandom_range(0, 5), 1'($urandom),
                    1'b0, 0, 8'($urandom), 8'($urandom));
        end

`ifdef VS1053_SCI_TIMEOUT_EN
        begin
            int lat_n;
            int low_n;
            lat_n = 0;
            low_n = 0;
            dreq = 1'b0;
            cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h07;
            tick;
            cmd_valid = 1'b0;
            while (!rsp_valid && lat_n < 300) begin
                if (!xcs || spi_wr_en) low_n++;
                tick;
                lat_n++;
            end
            chk("tmo_rsp_seen", {31'd0, rsp_valid}, 32'd1);
            chk("tmo_err", {31'd0, rsp_err}, 32'd1);
            chk("tmo_rdata", {16'd0, rsp_rdata}, 32'd0);
            chk("tmo_xcs_never_low", 32'(low_n), 32'd0);
            chk("tmo_latency", 32'(lat_n >= 99 && lat_n <= 103), 32'd1);
            tick;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vs1053_sci_ctrl.md
Name: vs1053_sci_ctrl

Overview:
- Command sequencer that sits directly upstream of the byte-level SPI master (CPOL0/CPHA0) in the MP3 player.
- Turns one VS1053 SCI register read or write into a chip-select-framed 4-byte SPI transaction: opcode, address, data high byte, data low byte.
- Drives the master's wr_en/data_in pair, consumes its rx_done/data_out, and returns the 16-bit read value to the control FSM.
- Gates every transaction on the codec's DREQ line.

Parameters:
- CS_SETUP_CYC, 2, clk cycles xcs is low before the first byte is issued (1..15)
- CS_HOLD_CYC, 2, clk cycles xcs stays low after the last rx_done (1..15)
- TIMEOUT_CYC, 65535, abort threshold; used only with the optional feature (1..2^20-1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, on clk
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_rw  in  1  1=read (opcode 0x03), 0=write (opcode 0x02)
- cmd_addr  in  8  SCI register address
- cmd_wdata  in  16  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data; 0x0000 after writes; held until next rsp_valid
- rsp_err  out  1  qualifies rsp_valid; tied 0 without the optional feature
- busy  out  1  ~cmd_ready
- dreq  in  1  VS1053 DREQ, already synchronised
- xcs  out  1  VS1053 XCS, active-low
- spi_wr_en  out  1  one-cycle byte-start pulse to the SPI master
- spi_tx  out  8  byte to the SPI master's data_in; stable while the byte is in flight
- spi_rx_done  in  1  one-cycle byte-complete pulse from the SPI master
- spi_rx  in  8  SPI master data_out; valid only in the cycle spi_rx_done=1

Behaviour:
- Reset values. All outputs registered.
  - xcs=1, spi_wr_en=0, spi_tx=0x00, rsp_valid=0, rsp_rdata=0x0000, rsp_err=0, cmd_ready=1.
  - State=IDLE, byte index=0.
- Command latch. On accept, latch rw, addr and wdata into a 32-bit frame {opcode, addr, wdata[15:8], wdata[7:0]}, then go to WAIT_DREQ.
- WAIT_DREQ: when dreq is sampled 1, go to CS_SETUP. xcs goes low the next cycle.
  - dreq is sampled only in this state. dreq dropping mid-transaction is ignored.
- CS_SETUP: count CS_SETUP_CYC cycles with xcs=0, then go to ISSUE.
- ISSUE (one cycle): spi_wr_en=1, spi_tx=frame byte[idx], then go to WAIT_BYTE.
- WAIT_BYTE: hold spi_tx and keep spi_wr_en=0 until spi_rx_done. On spi_rx_done:
  - if rw=read and idx=2, capture spi_rx into rdata[15:8]
  - if rw=read and idx=3, capture spi_rx into rdata[7:0]
  - if idx=3, go to CS_HOLD; otherwise idx+1 and go to ISSUE
- CS_HOLD: count CS_HOLD_CYC cycles with xcs=0, then set xcs=1 and go to RESP.
- RESP (one cycle): rsp_valid=1; rsp_rdata = captured value (read) or 0x0000 (write). Next state IDLE; cmd_ready=1 the cycle after.
- Byte spacing. Exactly 4 spi_wr_en pulses per transaction. A new pulse is never issued before the previous byte's spi_rx_done.
- Stray events:
  - spi_rx_done outside WAIT_BYTE is ignored.
  - cmd_valid while busy is not accepted; the requester holds it.
- Back-to-back commands: xcs is high for at least 2 cycles (RESP + IDLE) between transactions.
- Reset mid-operation: next cycle xcs=1 and spi_wr_en=0. The in-flight command is dropped with no rsp_valid. The SPI master shares rst.

Optional Feature:
- Macro VS1053_SCI_TIMEOUT_EN.
- Defined: a 20-bit counter runs in WAIT_DREQ and in WAIT_BYTE, clearing on every state entry. When it reaches TIMEOUT_CYC:
  - from WAIT_DREQ: go directly to RESP with rsp_err=1; xcs is never asserted.
  - from WAIT_BYTE: set xcs=1, go to RESP with rsp_err=1, rsp_rdata=0x0000.
- Not defined: no counter; the block waits indefinitely; rsp_err is constant 0.

Decomposition:
- Shared package vs1053_pkg:
  - SCI opcodes (SCI_READ=8'h03, SCI_WRITE=8'h02)
  - state encoding (IDLE, WAIT_DREQ, CS_SETUP, ISSUE, WAIT_BYTE, CS_HOLD, RESP)
  - counter widths
- One sub-module, vs1053_cycle_timer: loadable down-counter with a done flag, used by CS_SETUP, CS_HOLD and the timeout.

Test Plan:
- Write 0x0B/0x2020, dreq=1, SPI master behavioural model → spi_tx sequence 02,0B,20,20; 4 pulses; xcs low ≥2 cycles before first pulse and after last rx_done; rsp_valid with rdata=0x0000.
- Read 0x01, model returns spi_rx 00,00,AB,CD → rsp_rdata=0xABCD, rsp_err=0.
- dreq held 0 for 50 cycles after accept → xcs stays 1 and no spi_wr_en for 50 cycles; start within 2 cycles of dreq rising.
- Stray spi_rx_done during CS_SETUP, plus cmd_valid during busy → no index advance, second command accepted only after rsp_valid; xcs high ≥2 cycles between the two transactions.
- rst asserted during byte 2 → next cycle xcs=1 and spi_wr_en=0; no rsp_valid; a fresh command afterwards completes normally.
- VS1053_SCI_TIMEOUT_EN with TIMEOUT_CYC=100, dreq=0 → rsp_valid with rsp_err=1 at ~100 cycles after accept; xcs never low.
